// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, stall, flush and a saturating backpressure counter.
// Optional skid entry (registered in_ready, level up to 2) enabled by defining PIPE_SKID_EN.
module pipe_stage_reg #(
    parameter int WIDTH           = 128,
    parameter bit CLEAR_ON_BUBBLE = 1'b1,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             stall,
    input  logic             flush,
    output logic [1:0]       level,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             accept;
    logic             load;
    logic [WIDTH-1:0] main_bubble;

    assign accept      = main_valid_q & out_ready & ~stall;
    assign load        = in_valid & in_ready;
    assign main_bubble = CLEAR_ON_BUBBLE ? '0 : main_data_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid_q && !accept && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

`ifdef PIPE_SKID_EN
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [WIDTH-1:0] skid_bubble;

    assign skid_bubble = CLEAR_ON_BUBBLE ? '0 : skid_data_q;
    // Ready comes only from state plus the local hold inputs, never from out_ready.
    assign in_ready    = ~flush & ~stall & ~skid_valid_q;
    assign level       = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = main_bubble;
            skid_valid_d = 1'b0;
            skid_data_d  = skid_bubble;
        end else if (!stall) begin
            if (skid_valid_q) begin
                if (accept) begin
                    main_data_d  = skid_data_q;
                    skid_valid_d = 1'b0;
                    skid_data_d  = skid_bubble;
                end
            end else if (main_valid_q && !accept) begin
                if (load) begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = in_data;
                end
            end else if (load) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end else if (accept) begin
                main_valid_d = 1'b0;
                main_data_d  = main_bubble;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end
`else
    // Single entry: a full stage can still load when downstream drains it this cycle.
    assign in_ready = ~flush & ~stall & (~main_valid_q | out_ready);
    assign level    = {1'b0, main_valid_q};

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = main_bubble;
        end else if (!stall) begin
            if (load) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end else if (accept) begin
                main_valid_d = 1'b0;
                main_data_d  = main_bubble;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (32-bit payload, 4-bit stall counter).
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        stall;
    logic        flush;
    logic [1:0]  level;
    logic [3:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.WIDTH(32), .CLEAR_ON_BUBBLE(1'b1), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall(stall), .flush(flush), .level(level), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF;
        out_ready = 1'b1; stall = 1'b0; flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid cyc%0d: got %b want 0", c, out_valid); end
            checks++;
            if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data cyc%0d: got %h want 0", c, out_data); end
            checks++;
            if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall_cnt cyc%0d: got %0d want 0", c, stall_cnt); end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL first_beat: got v=%b d=%h want v=1 d=deadbeef", out_valid, out_data);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            errors++; $display("FAIL bubble_clear: got v=%b d=%h want v=0 d=0", out_valid, out_data);
        end
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 32'(i);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
                errors++; $display("FAIL stream_beat%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, i);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || stall_cnt !== 4'd0) begin
            errors++; $display("FAIL stream_end: got v=%b cnt=%0d want v=0 cnt=0", out_valid, stall_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] beats [3];
        int          k;
        int          n;
        logic        fire;
        logic [1:0]  exp_level;
        int          exp_taken;
        beats[0] = 32'h21; beats[1] = 32'h22; beats[2] = 32'h23;
        k = 0; n = 0;
`ifdef PIPE_SKID_EN
        exp_level = 2'd2; exp_taken = 2;
`else
        exp_level = 2'd1; exp_taken = 1;
`endif
        do_reset();
        out_ready = 1'b0;
        // One loading edge, then five edges of held backpressure.
        for (int c = 0; c < 6; c++) begin
            in_valid = (k < 3);
            in_data  = (k < 3) ? beats[k] : 32'h0;
            #1;
            fire = in_valid & in_ready;
            tick();
            if (fire) k++;
        end
        checks++;
        if (stall_cnt !== 4'd5) begin errors++; $display("FAIL bp_stall_cnt: got %0d want 5", stall_cnt); end
        checks++;
        if (level !== exp_level) begin errors++; $display("FAIL bp_level: got %0d want %0d", level, exp_level); end
        checks++;
        if (k !== exp_taken) begin errors++; $display("FAIL bp_beats_taken: got %0d want %0d", k, exp_taken); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h21) begin
            errors++; $display("FAIL bp_head: got v=%b d=%h want v=1 d=21", out_valid, out_data);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 10 && n < 3; c++) begin
            in_valid = (k < 3);
            in_data  = (k < 3) ? beats[k] : 32'h0;
            #1;
            fire = in_valid & in_ready;
            if (out_valid) begin
                checks++;
                if (out_data !== beats[n]) begin
                    errors++; $display("FAIL bp_order%0d: got %h want %h", n, out_data, beats[n]);
                end
                n++;
            end
            tick();
            if (fire) k++;
        end
        in_valid = 1'b0;
        checks++;
        if (n !== 3) begin errors++; $display("FAIL bp_drain_count: got %0d want 3", n); end
        checks++;
        if (out_valid !== 1'b0 || level !== 2'd0) begin
            errors++; $display("FAIL bp_empty: got v=%b level=%0d want v=0 level=0", out_valid, level);
        end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        tick();
        flush = 1'b1; stall = 1'b1; in_data = 32'h77;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || level !== 2'd0) begin
            errors++; $display("FAIL flush_clear: got v=%b d=%h lvl=%0d want v=0 d=0 lvl=0", out_valid, out_data, level);
        end
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped_beat: got v=%b want 0", out_valid); end
    endtask

    task automatic test_stall_hold();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h99;
        tick();
        in_data = 32'hAA;
        stall   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc%0d: got %b want 0", c, in_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h99) begin
                errors++; $display("FAIL stall_hold cyc%0d: got v=%b d=%h want v=1 d=99", c, out_valid, out_data);
            end
        end
        checks++;
        if (stall_cnt !== 4'd3) begin errors++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt); end
        stall    = 1'b0;
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || stall_cnt !== 4'd3) begin
            errors++; $display("FAIL stall_release: got v=%b cnt=%0d want v=0 cnt=3", out_valid, stall_cnt);
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h3C;
        for (int c = 1; c <= 20; c++) begin
            tick();
            in_valid = 1'b0;
            exp_cnt = (c - 1 > 15) ? 15 : c - 1;
            if (c >= 14) begin
                checks++;
                if (stall_cnt !== 4'(exp_cnt)) begin
                    errors++; $display("FAIL sat_cnt cyc%0d: got %0d want %0d", c, stall_cnt, exp_cnt);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_stall_hold();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
